// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: combines memory-access freeze/conflict flags, load-use
// detection and branch redirects into PC and pipeline-register strobes, plus debug counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_conflict,
    input  logic             no_stop,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_rs_use,
    input  logic             id_rt_use,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             branch_taken,
    input  logic [15:0]      branch_target,
    input  logic             cnt_clear,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pc_sel,
    output logic [15:0]      pc_target,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [REG_W-1:0] REG_NONE = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {RUN = 1'b0, FREEZE = 1'b1} state_t;

    state_t      state, state_nxt;
    logic        pend_v, pend_v_nxt;
    logic [15:0] pend_pc, pend_pc_nxt;
    logic        freeze_inc, bubble_inc;
    logic        load_use;

    assign load_use = ex_mem_read && (ex_rd != REG_NONE) &&
                      ((id_rs_use && (id_rs == ex_rd)) || (id_rt_use && (id_rt == ex_rd)));

    // Priority decode: freeze > redirect > load-use > fetch conflict > run.
    // A pending redirect only exists after a freeze, so it is qualified by FREEZE.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_sel      = 1'b0;
        pc_target   = 16'h0000;
        state_nxt   = RUN;
        pend_v_nxt  = pend_v;
        pend_pc_nxt = pend_pc;
        freeze_inc  = 1'b0;
        bubble_inc  = 1'b0;

        if (!no_stop) begin
            pc_en      = 1'b0;
            if_id_en   = 1'b0;
            id_ex_en   = 1'b0;
            ex_mem_en  = 1'b0;
            mem_wb_en  = 1'b0;
            state_nxt  = FREEZE;
            freeze_inc = 1'b1;
            if (branch_taken) begin
                pend_v_nxt  = 1'b1;
                pend_pc_nxt = branch_target;
            end
        end else if (branch_taken || (pend_v && state == FREEZE)) begin
            pc_sel      = 1'b1;
            if_id_flush = 1'b1;
            pc_target   = branch_taken ? branch_target : pend_pc;
            pend_v_nxt  = 1'b0;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            bubble_inc  = 1'b1;
        end else if (mem_conflict) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
            bubble_inc  = 1'b1;
        end

        if (!rst) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            mem_wb_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pc_sel      = 1'b0;
            pc_target   = 16'h0000;
        end
    end

    // State, pending redirect and saturating counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            pend_v     <= 1'b0;
            pend_pc    <= 16'h0000;
            freeze_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pend_v  <= pend_v_nxt;
            pend_pc <= pend_pc_nxt;

            if (cnt_clear)
                freeze_cnt <= '0;
            else if (freeze_inc && freeze_cnt != CNT_MAX)
                freeze_cnt <= freeze_cnt + CNT_W'(1);

            if (cnt_clear)
                bubble_cnt <= '0;
            else if (bubble_inc && bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_conflict, no_stop, ex_mem_read;
    logic [3:0]  ex_rd, id_rs, id_rt;
    logic        id_rs_use, id_rt_use, branch_taken, cnt_clear;
    logic [15:0] branch_target;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, pc_sel;
    logic [15:0] pc_target, freeze_cnt, bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .mem_conflict(mem_conflict), .no_stop(no_stop), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .id_rs_use(id_rs_use), .id_rt_use(id_rt_use),
        .id_rs(id_rs), .id_rt(id_rt),
        .branch_taken(branch_taken), .branch_target(branch_target), .cnt_clear(cnt_clear),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .pc_sel(pc_sel), .pc_target(pc_target),
        .freeze_cnt(freeze_cnt), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic        ns, mc, bt;
        logic [15:0] tgt;
        logic        mr;
        logic [3:0]  rd;
        logic        rsu;
        logic [3:0]  rs;
        logic        rtu;
        logic [3:0]  rt;
        logic [4:0]  en;
        logic [1:0]  fl;
        logic        sel;
        logic        bub, frz;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [4:0] en_now();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    endfunction

    function automatic logic [1:0] fl_now();
        return {if_id_flush, id_ex_flush};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        no_stop = 1'b1; mem_conflict = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        ex_mem_read = 1'b0; ex_rd = 4'hF; id_rs_use = 1'b0; id_rs = 4'h0;
        id_rt_use = 1'b0; id_rt = 4'h0; cnt_clear = 1'b0;
    endtask

    task automatic clear_counters();
        @(negedge clk);
        set_idle();
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
    endtask

    initial begin
        logic [15:0] fc0, bc0;
        set_idle();
        rst = 1'b0;
        #2;
        chk("reset_en", 32'(en_now()), 32'h00);
        chk("reset_flush", 32'(fl_now()), 32'h3);
        chk("reset_pc_sel", 32'(pc_sel), 32'h0);
        chk("reset_pc_target", 32'(pc_target), 32'h0);
        chk("reset_cnts", {freeze_cnt, bubble_cnt}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        //            ns   mc   bt   tgt       mr   rd    rsu  rs    rtu  rt    en        fl     sel  bub  frz
        vecs[0]  = '{1'b1,1'b0,1'b0,16'h0000,1'b0,4'hF,1'b0,4'h0,1'b0,4'h0,5'b11111,2'b00,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,16'h0000,1'b1,4'h3,1'b1,4'h3,1'b0,4'h0,5'b00111,2'b01,1'b0,1'b1,1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,16'h0000,1'b1,4'h5,1'b0,4'h5,1'b1,4'h5,5'b00111,2'b01,1'b0,1'b1,1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b0,16'h0000,1'b1,4'h3,1'b0,4'h3,1'b0,4'h3,5'b11111,2'b00,1'b0,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,16'h0000,1'b0,4'h3,1'b1,4'h3,1'b1,4'h3,5'b11111,2'b00,1'b0,1'b0,1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b0,16'h0000,1'b1,4'hF,1'b1,4'hF,1'b1,4'hF,5'b11111,2'b00,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b0,16'h0000,1'b0,4'hF,1'b0,4'h0,1'b0,4'h0,5'b01111,2'b10,1'b0,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b0,16'h0000,1'b1,4'h2,1'b1,4'h2,1'b0,4'h0,5'b00111,2'b01,1'b0,1'b1,1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b1,16'h1234,1'b0,4'hF,1'b0,4'h0,1'b0,4'h0,5'b11111,2'b10,1'b1,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b1,16'hBEEF,1'b1,4'h7,1'b1,4'h7,1'b0,4'h0,5'b11111,2'b10,1'b1,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b1,1'b1,16'h0010,1'b0,4'hF,1'b0,4'h0,1'b0,4'h0,5'b11111,2'b10,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b0,16'h0000,1'b1,4'h3,1'b1,4'h3,1'b0,4'h0,5'b00000,2'b00,1'b0,1'b0,1'b1};
        vecs[12] = '{1'b1,1'b0,1'b0,16'h0000,1'b0,4'hF,1'b0,4'h0,1'b0,4'h0,5'b11111,2'b00,1'b0,1'b0,1'b0};

        clear_counters();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            no_stop = vecs[i].ns; mem_conflict = vecs[i].mc; branch_taken = vecs[i].bt;
            branch_target = vecs[i].tgt; ex_mem_read = vecs[i].mr; ex_rd = vecs[i].rd;
            id_rs_use = vecs[i].rsu; id_rs = vecs[i].rs; id_rt_use = vecs[i].rtu; id_rt = vecs[i].rt;
            #1;
            fc0 = freeze_cnt; bc0 = bubble_cnt;
            chk($sformatf("vec%0d_en", i), 32'(en_now()), 32'(vecs[i].en));
            chk($sformatf("vec%0d_flush", i), 32'(fl_now()), 32'(vecs[i].fl));
            chk($sformatf("vec%0d_pc_sel", i), 32'(pc_sel), 32'(vecs[i].sel));
            if (vecs[i].sel)
                chk($sformatf("vec%0d_pc_target", i), 32'(pc_target), 32'(vecs[i].tgt));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_bubble_cnt", i), 32'(bubble_cnt), 32'(bc0 + 16'(vecs[i].bub)));
            chk($sformatf("vec%0d_freeze_cnt", i), 32'(freeze_cnt), 32'(fc0 + 16'(vecs[i].frz)));
        end

        // Load-use lasts one cycle, bubble_cnt 0 -> 1, then back to full advance.
        clear_counters();
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 4'h3; id_rs_use = 1'b1; id_rs = 4'h3;
        #1;
        chk("lu_pc_en", 32'(pc_en), 32'h0);
        chk("lu_if_id_en", 32'(if_id_en), 32'h0);
        chk("lu_id_ex_flush", 32'(id_ex_flush), 32'h1);
        @(posedge clk); #1;
        chk("lu_bubble_cnt", 32'(bubble_cnt), 32'h1);
        @(negedge clk);
        set_idle();
        #1;
        chk("lu_after_en", 32'(en_now()), 32'h1F);

        // Five frozen cycles, then immediate release.
        clear_counters();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            no_stop = 1'b0;
            #1;
            chk($sformatf("frz%0d_en", i), 32'(en_now()), 32'h00);
            chk($sformatf("frz%0d_flush", i), 32'(fl_now()), 32'h0);
        end
        @(negedge clk);
        no_stop = 1'b1;
        #1;
        chk("frz_cnt5", 32'(freeze_cnt), 32'h5);
        chk("frz_release_en", 32'(en_now()), 32'h1F);
        chk("frz_release_pc_sel", 32'(pc_sel), 32'h0);

        // Branch in the 2nd frozen cycle is held until release.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            no_stop = 1'b0;
            branch_taken = (i == 1);
            branch_target = (i == 1) ? 16'h4020 : 16'h0000;
            #1;
            chk($sformatf("bfrz%0d_pc_en", i), 32'(pc_en), 32'h0);
            chk($sformatf("bfrz%0d_pc_sel", i), 32'(pc_sel), 32'h0);
        end
        @(negedge clk);
        set_idle();
        #1;
        chk("bfrz_rel_pc_sel", 32'(pc_sel), 32'h1);
        chk("bfrz_rel_pc_target", 32'(pc_target), 32'h4020);
        chk("bfrz_rel_if_id_flush", 32'(if_id_flush), 32'h1);
        chk("bfrz_rel_pc_en", 32'(pc_en), 32'h1);
        @(negedge clk);
        #1;
        chk("bfrz_after_pc_sel", 32'(pc_sel), 32'h0);
        chk("bfrz_after_flush", 32'(if_id_flush), 32'h0);

        // Two branches while frozen: newer target wins; then a fresh pulse at release wins too.
        @(negedge clk);
        no_stop = 1'b0; branch_taken = 1'b1; branch_target = 16'h1111;
        @(negedge clk);
        branch_target = 16'h2222;
        @(negedge clk);
        branch_taken = 1'b0;
        @(negedge clk);
        no_stop = 1'b1;
        #1;
        chk("newer_pc_target", 32'(pc_target), 32'h2222);
        @(negedge clk);
        no_stop = 1'b0; branch_taken = 1'b1; branch_target = 16'h3333;
        @(negedge clk);
        no_stop = 1'b1; branch_target = 16'h4444;
        #1;
        chk("release_pulse_target", 32'(pc_target), 32'h4444);
        @(negedge clk);
        set_idle();
        #1;
        chk("release_pulse_no_repeat", 32'(pc_sel), 32'h0);

        // Saturation and clear of freeze_cnt.
        clear_counters();
        @(negedge clk);
        no_stop = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_freeze_cnt", 32'(freeze_cnt), 32'hFFFF);
        @(negedge clk);
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        chk("clear_freeze_cnt", 32'(freeze_cnt), 32'h0);

        // Asynchronous reset mid-freeze with a pending redirect.
        @(negedge clk);
        cnt_clear = 1'b0; branch_taken = 1'b1; branch_target = 16'h5555;
        @(negedge clk);
        branch_taken = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_en", 32'(en_now()), 32'h00);
        chk("arst_flush", 32'(fl_now()), 32'h3);
        chk("arst_pc_sel_target", {15'h0, pc_sel, pc_target}, 32'h0);
        chk("arst_cnt", 32'(freeze_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        #1;
        chk("arst_rel_pc_sel", 32'(pc_sel), 32'h0);
        chk("arst_rel_en", 32'(en_now()), 32'h1F);
        @(negedge clk);
        #1;
        chk("arst_rel2_pc_sel", 32'(pc_sel), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline stall/flush controller that sits directly downstream of the memory-access module. It consumes that module's `MemConflict` (instruction fetch lost to a data access on RAM1) and `noStop` (serial-port access in progress) flags. It combines them with load-use detection and branch redirects, and drives the enable/flush strobes of the PC and the four pipeline registers. It also holds a branch redirect that arrives during a freeze until the PC can accept it, and keeps two saturating stall counters for debug.

## Interface

Parameters:
- `REG_W`, 4: register-index width (8 GPR + SP/IH/RA/T).
- `CNT_W`, 16: stall counter width.

Ports:
- `clk` input 1: CPU clock; state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `mem_conflict` input 1: fetch this cycle was replaced by NOP.
- `no_stop` input 1: 0 means UART access in progress; freeze the pipeline.
- `ex_mem_read` input 1: the instruction in EX is a load.
- `ex_rd` input `REG_W`: destination of the EX instruction; 4'hF means none.
- `id_rs_use`, `id_rt_use` input 1: ID actually reads rs / rt.
- `id_rs`, `id_rt` input `REG_W`: ID source indices.
- `branch_taken` input 1: single-cycle pulse from ID; the redirect is valid only in that cycle.
- `branch_target` input 16: target PC, valid with `branch_taken`.
- `cnt_clear` input 1: synchronous clear of both counters.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` output 1: load enables.
- `if_id_flush`, `id_ex_flush` output 1: load a NOP/bubble instead of data; a flush is meaningful only together with the matching enable.
- `pc_sel` output 1: 1 means the PC loads `pc_target`; 0 means PC+1.
- `pc_target` output 16: redirect address.
- `freeze_cnt`, `bubble_cnt` output `CNT_W`: saturating counters.

## Operation

- Two states: RUN and FREEZE. Pending-redirect register: `pend_v`, `pend_pc`.
- The outputs below are combinational from the inputs plus state. Evaluate the rows in priority order; the first match wins.
  1. `no_stop==0` (freeze):
     - All five enables are 0 and both flushes are 0.
     - If `branch_taken`, capture `pend_v=1` and `pend_pc=branch_target` at the clock edge.
     - Next state is FREEZE.
  2. Redirect (`branch_taken`, or `pend_v` while `no_stop==1`):
     - All enables are 1, `pc_sel=1`, and `if_id_flush=1`.
     - `pc_target` is `branch_target` if `branch_taken`, otherwise `pend_pc`.
     - `pend_v` clears at the edge.
     - This row overrides `mem_conflict`: the NOP it inserted is flushed anyway.
  3. Load-use hazard, `ex_mem_read && ex_rd!=4'hF && ((id_rs_use && id_rs==ex_rd) || (id_rt_use && id_rt==ex_rd))`:
     - `pc_en=0`, `if_id_en=0`, `id_ex_en=1`, `id_ex_flush=1`.
     - `ex_mem_en=1` and `mem_wb_en=1`.
  4. `mem_conflict`:
     - `pc_en=0`, so the same PC is refetched.
     - `if_id_en=1` with `if_id_flush=1`.
     - All later stages advance.
  5. Otherwise: all enables 1, no flushes, `pc_sel=0`.
- FREEZE returns to RUN on the first edge with `no_stop==1`. There is no extra release cycle; rows 2–5 apply in that same cycle.
- `branch_taken` while `pend_v==1`: the new pulse wins (newer target).
- `freeze_cnt` increments on every edge where row 1 applies.
- `bubble_cnt` increments on every edge where row 3 or row 4 applies.
- Both counters saturate at all-ones with no wrap. `cnt_clear` has priority over increment.

## Timing

- Strobe latency is 0 cycles: strobes respond combinationally in the same cycle as the flags.
- State, `pend_*` and the counters update on the rising edge.
- While `rst==0`, and asynchronously:
  - state = RUN, `pend_v=0`, `pend_pc=0`, counters = 0.
  - All enables 0, both flushes 1, `pc_sel=0`, `pc_target=0`.
- Reset asserted mid-freeze discards any pending redirect.
- The first edge after `rst` rises behaves as RUN.
- A load-use hazard lasts exactly one cycle: the bubble moves the load to MEM, so the compare fails on the next cycle.
- A conflict lasts one cycle per data access as seen by this block.

## Test plan

- Load-use: `ex_mem_read=1`, `ex_rd=3`, `id_rs_use=1`, `id_rs=3` for one cycle.
  - That cycle: `pc_en=0`, `if_id_en=0`, `id_ex_flush=1`.
  - `bubble_cnt` goes 0→1; the next cycle is back to all enables 1.
- With `ex_rd=4'hF` and sources 15/15 (both `*_use` asserted): no stall.
- Freeze: hold `no_stop=0` for 5 cycles.
  - All enables 0 throughout; `freeze_cnt=5`.
  - On the first cycle `no_stop=1`, enables are 1.
- Branch during freeze: `branch_taken` pulse with target 16'h4020 in the 2nd frozen cycle.
  - No PC write until `no_stop=1`.
  - Then exactly one cycle with `pc_sel=1`, `pc_target=16'h4020`, `if_id_flush=1`, `pc_en=1`.
- Conflict plus branch in the same cycle (`mem_conflict=1`, `branch_taken=1`, target 16'h0010):
  - `pc_en=1`, `pc_sel=1`, `if_id_flush=1`; `bubble_cnt` unchanged.
- Saturation and clear: preload by running 65 540 freeze cycles.
  - `freeze_cnt` holds 16'hFFFF.
  - `cnt_clear=1` together with `no_stop=0` gives 0 on the next edge.
- Reset mid-freeze with `pend_v=1`: assert `rst=0` asynchronously.
  - Outputs take their reset values immediately.
  - After release there is no redirect; `pc_sel=0`.
